// File: rtl/audio_pkg.sv
// Shared types, widths and saturating level helpers for the tone path.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int HALF_W   = 8;
    localparam int DIV_W    = 4;
    // One bit of headroom above the sample magnitude so the envelope
    // arithmetic can detect overflow and saturate instead of wrapping.
    localparam int LEVEL_W  = 17;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    // Envelope step up, clamped at the peak level.
    function automatic logic [LEVEL_W-1:0] sat_add(
        input logic [LEVEL_W-1:0] a,
        input logic [LEVEL_W-1:0] b,
        input logic [LEVEL_W-1:0] limit
    );
        logic [LEVEL_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, limit}) begin
            sat_add = limit;
        end else begin
            sat_add = sum[LEVEL_W-1:0];
        end
    endfunction

    // Envelope step down, clamped at zero.
    function automatic logic [LEVEL_W-1:0] sat_sub(
        input logic [LEVEL_W-1:0] a,
        input logic [LEVEL_W-1:0] b
    );
        if (a > b) begin
            sat_sub = a - b;
        end else begin
            sat_sub = {LEVEL_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every SAMPLE_DIV clocks.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 1042
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             tick_r;

    // Next counter value: wrap after the last count of the sample period.
    always_comb begin
        count_next_s = count_r;
        if (count_r == LAST) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            count_next_s = count_r + CNT_W'(1);
        end
    end

    // Counter register; tick is registered so it is high exactly while count==LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            tick_r  <= (count_next_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone synthesiser with linear attack/release envelope and a
// valid/ready sample output running at the audio sample rate.
module tone_generator
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV = 1042,
    parameter int BASE_HALF  = 6,
    parameter int AMPLITUDE  = 8192,
    parameter int RAMP_STEP  = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enabled,
    input  logic [DIV_W-1:0]    divisor,
    input  logic                sample_ready,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                busy,
    output logic                overrun
);

    localparam logic [HALF_W-1:0]  BASE_HALF_C = HALF_W'(BASE_HALF);
    localparam logic [LEVEL_W-1:0] AMP_C       = LEVEL_W'(AMPLITUDE);
    localparam logic [LEVEL_W-1:0] STEP_C      = LEVEL_W'(RAMP_STEP);

    logic                tick_s;
    logic                note_on_s;
    logic [HALF_W-1:0]   div_half_s;
    logic [LEVEL_W-1:0]  level_up_s;
    logic [LEVEL_W-1:0]  level_down_s;
    logic [SAMPLE_W-1:0] sample_s;

    env_state_t          state_r;
    env_state_t          state_next_s;
    logic [LEVEL_W-1:0]  level_r;
    logic [LEVEL_W-1:0]  level_next_s;
    logic                polarity_r;
    logic                polarity_next_s;
    logic [HALF_W-1:0]   half_cnt_r;
    logic [HALF_W-1:0]   half_cnt_next_s;
    logic [HALF_W-1:0]   half_period_r;
    logic [HALF_W-1:0]   half_period_next_s;

    logic                valid_r;
    logic                valid_next_s;
    logic [SAMPLE_W-1:0] data_r;
    logic [SAMPLE_W-1:0] data_next_s;
    logic                overrun_r;
    logic                overrun_next_s;
    logic                busy_r;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Derived request and candidate envelope levels for this tick.
    always_comb begin
        note_on_s    = enabled && (divisor != DIV_W'(0));
        div_half_s   = BASE_HALF_C * {{(HALF_W - DIV_W){1'b0}}, divisor};
        level_up_s   = sat_add(level_r, STEP_C, AMP_C);
        level_down_s = sat_sub(level_r, STEP_C);
    end

    // Envelope FSM and phase accumulator: everything moves only on a tick.
    always_comb begin
        state_next_s       = state_r;
        level_next_s       = level_r;
        polarity_next_s    = polarity_r;
        half_cnt_next_s    = half_cnt_r;
        half_period_next_s = half_period_r;
        if (tick_s) begin
            // Phase runs whenever a tone is sounding; a new divisor is only
            // adopted at a polarity flip so the waveform never glitches.
            if (state_r != ENV_IDLE) begin
                if (half_cnt_r == (half_period_r - HALF_W'(1))) begin
                    polarity_next_s = ~polarity_r;
                    half_cnt_next_s = HALF_W'(0);
                    if (divisor != DIV_W'(0)) begin
                        half_period_next_s = div_half_s;
                    end else begin
                        half_period_next_s = half_period_r;
                    end
                end else begin
                    half_cnt_next_s = half_cnt_r + HALF_W'(1);
                end
            end else begin
                half_cnt_next_s = half_cnt_r;
            end

            case (state_r)
                ENV_IDLE: begin
                    if (note_on_s) begin
                        half_period_next_s = div_half_s;
                        half_cnt_next_s    = HALF_W'(0);
                        polarity_next_s    = 1'b1;
                        level_next_s       = level_up_s;
                        state_next_s       = (level_up_s == AMP_C) ? ENV_SUSTAIN : ENV_ATTACK;
                    end else begin
                        level_next_s = LEVEL_W'(0);
                    end
                end
                // Attack, sustain and release share one rule: the step taken
                // on this tick follows the direction the request now asks for.
                // Sustain at the peak is attack with a saturated increment.
                ENV_ATTACK, ENV_SUSTAIN, ENV_RELEASE: begin
                    if (note_on_s) begin
                        level_next_s = level_up_s;
                        state_next_s = (level_up_s == AMP_C) ? ENV_SUSTAIN : ENV_ATTACK;
                    end else begin
                        level_next_s = level_down_s;
                        state_next_s = (level_down_s == LEVEL_W'(0)) ? ENV_IDLE : ENV_RELEASE;
                    end
                end
                default: begin
                    state_next_s = ENV_IDLE;
                    level_next_s = LEVEL_W'(0);
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Signed sample from the post-update level and polarity.
    always_comb begin
        if (polarity_next_s) begin
            sample_s = level_next_s[SAMPLE_W-1:0];
        end else begin
            sample_s = SAMPLE_W'(0) - level_next_s[SAMPLE_W-1:0];
        end
    end

    // Output handshake: load on tick when the slot is free, else hold and flag overrun.
    always_comb begin
        valid_next_s   = valid_r;
        data_next_s    = data_r;
        overrun_next_s = 1'b0;
        if (tick_s) begin
            if (!valid_r || sample_ready) begin
                valid_next_s = 1'b1;
                data_next_s  = sample_s;
            end else begin
                overrun_next_s = 1'b1;
            end
        end else if (valid_r && sample_ready) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = valid_r;
        end
    end

    // Synthesis state registers, with busy tracking the envelope state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ENV_IDLE;
            level_r       <= LEVEL_W'(0);
            polarity_r    <= 1'b1;
            half_cnt_r    <= HALF_W'(0);
            half_period_r <= HALF_W'(0);
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            level_r       <= level_next_s;
            polarity_r    <= polarity_next_s;
            half_cnt_r    <= half_cnt_next_s;
            half_period_r <= half_period_next_s;
            busy_r        <= (state_next_s != ENV_IDLE);
        end
    end

    // Output sample registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            data_r    <= SAMPLE_W'(0);
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= valid_next_s;
            data_r    <= data_next_s;
            overrun_r <= overrun_next_s;
        end
    end

    assign sample_valid = valid_r;
    assign sample_data  = data_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator: vector tables for note on, release
// and divisor change, hand sequences for backpressure and mid-tone reset, and
// a randomized run against a per-tick reference model.
module tb_tone_generator;

    localparam int DIVC = 4;
    localparam int BH   = 2;
    localparam int AMP  = 1024;
    localparam int STEP = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        enabled;
    logic [3:0]  divisor;
    logic        sample_ready;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    tone_generator #(
        .SAMPLE_DIV (DIVC),
        .BASE_HALF  (BH),
        .AMPLITUDE  (AMP),
        .RAMP_STEP  (STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enabled      (enabled),
        .divisor      (divisor),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    typedef struct {
        bit rst_before;
        bit en;
        int div;
        int exp_data;
        bit exp_busy;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: tone level, square-wave phase, output slot.
    int m_level, m_pos, m_hp, m_data, m_cnt;
    bit m_pol, m_valid, m_ovr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add_row(input bit r, input bit e, input int d, input int x, input bit b);
        vec_t v;
        v.rst_before = r;
        v.en         = e;
        v.div        = d;
        v.exp_data   = x;
        v.exp_busy   = b;
        vecs.push_back(v);
    endtask

    // One clock of the model: a tick every DIVC clocks; a silent tone starts
    // on request, a sounding tone steps its phase and ramps toward the target.
    task automatic model_cycle(input bit r, input bit en, input int dv, input bit rdy);
        bit note;
        int s;
        bit ovr_n;
        if (r) begin
            m_level = 0; m_pos = 0; m_hp = 0; m_pol = 1'b1;
            m_valid = 1'b0; m_data = 0; m_ovr = 1'b0; m_cnt = 0;
            return;
        end
        ovr_n = 1'b0;
        if (m_cnt == DIVC - 1) begin
            note = en && (dv != 0);
            if (m_level == 0) begin
                if (note) begin
                    m_hp = BH * dv; m_pos = 0; m_pol = 1'b1;
                    m_level = (STEP < AMP) ? STEP : AMP;
                end
            end else begin
                if (m_pos == m_hp - 1) begin
                    m_pol = !m_pol; m_pos = 0;
                    if (dv != 0) m_hp = BH * dv;
                end else begin
                    m_pos++;
                end
                if (note) m_level = (m_level + STEP > AMP) ? AMP : m_level + STEP;
                else      m_level = (m_level - STEP < 0) ? 0 : m_level - STEP;
            end
            s = m_pol ? m_level : -m_level;
            if (!m_valid || rdy) begin
                m_valid = 1'b1; m_data = s;
            end else begin
                ovr_n = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_ovr = ovr_n;
        m_cnt = (m_cnt + 1) % DIVC;
    endtask

    task automatic cycle_check(input string tag);
        model_cycle(rst, enabled, int'(divisor), sample_ready);
        @(negedge clk);
        check({tag, " valid"},   int'(sample_valid), int'(m_valid));
        check({tag, " data"},    int'($signed(sample_data)), m_data);
        check({tag, " busy"},    int'(busy), int'(m_level != 0));
        check({tag, " overrun"}, int'(overrun), int'(m_ovr));
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("valid wait", int'(ok), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; enabled = 1'b0; divisor = 4'd0; sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_a[17] = '{256, 512, 768, 1024, 1024, 1024, 1024, 1024,
                          -1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024, 1024};
        int exp_b[5]  = '{-768, -512, -256, 0, 0};
        int exp_c[17] = '{256, 512, 768, 1024, 1024, 1024, 1024, 1024,
                          -1024, -1024, -1024, -1024, 1024, 1024, 1024, 1024, -1024};
        int last;
        int nvalid;
        int ovr_cnt;

        // Note on with a sustained tone over one full period.
        for (int k = 0; k < 17; k++) add_row(k == 0, 1'b1, 4, exp_a[k], 1'b1);
        // Release after twelve samples, polarity continuing.
        for (int k = 0; k < 12; k++) add_row(k == 0, 1'b1, 4, exp_a[k], 1'b1);
        for (int k = 0; k < 5; k++)  add_row(1'b0, 1'b0, 4, exp_b[k], k < 3);
        // Divisor change mid half-period.
        for (int k = 0; k < 17; k++) add_row(k == 0, 1'b1, (k < 3) ? 4 : 2, exp_c[k], 1'b1);

        rst = 1'b1; enabled = 1'b0; divisor = 4'd0; sample_ready = 1'b1;

        // Reset and silence.
        for (int i = 0; i < 3; i++) cycle_check("reset");
        rst = 1'b0;
        last = -1; nvalid = 0;
        for (int i = 0; i < 24; i++) begin
            cycle_check("silence");
            if (sample_valid) begin
                nvalid++;
                if (last >= 0) check("silence spacing", i - last, DIVC);
                last = i;
            end
        end
        check("silence count", int'(nvalid >= 4), 1);

        // Vector table: each row is one accepted sample.
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            enabled = vecs[i].en;
            divisor = 4'(vecs[i].div);
            wait_valid();
            check($sformatf("vec%0d data", i), int'($signed(sample_data)), vecs[i].exp_data);
            check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
        end

        // Backpressure: hold for nine cycles across two ticks.
        do_reset();
        enabled = 1'b1; divisor = 4'd4;
        wait_valid();
        check("bp first", int'($signed(sample_data)), STEP);
        sample_ready = 1'b0;
        ovr_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("bp held valid", int'(sample_valid), 1);
            check("bp held data", int'($signed(sample_data)), STEP);
            if (overrun) ovr_cnt++;
        end
        check("bp overrun count", ovr_cnt, 2);
        sample_ready = 1'b1;
        wait_valid();
        check("bp resume data", int'($signed(sample_data)), 4 * STEP);

        // Reset during sustain, then silence with the request dropped.
        do_reset();
        enabled = 1'b1; divisor = 4'd4;
        repeat (6) wait_valid();
        check("mid busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst valid", int'(sample_valid), 0);
        check("mid rst data", int'($signed(sample_data)), 0);
        check("mid rst busy", int'(busy), 0);
        rst = 1'b0; enabled = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("post rst data", int'($signed(sample_data)), 0);
            check("post rst busy", int'(busy), 0);
            if (sample_valid) nvalid++;
        end
        check("post rst stream", int'(nvalid >= 3), 1);

        // Randomized run against the model.
        rst = 1'b1; enabled = 1'b1; divisor = 4'd3; sample_ready = 1'b1;
        cycle_check("rand rst");
        cycle_check("rand rst");
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) enabled = ~enabled;
            if ($urandom_range(0, 59) == 0) divisor = 4'($urandom_range(0, 15));
            sample_ready = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 999) == 0);
            cycle_check("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
